// File: rtl/axi_lite_if.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_lite_if: AXI-Lite bundle (AR/R/AW/W/B) shared by masters and slaves. Rev 1.0
// ------------------------------------------------------------------
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wmask;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wmask, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// axi_lite_arbiter: 2:1 AXI-Lite arbiter, one transaction in flight at a time.
// Define AXI_LITE_ARBITER_RR_EN for round-robin tie-break (default: fixed). Rev 1.0
// ------------------------------------------------------------------
module axi_lite_arbiter #(
  parameter int DEFAULT_GRANT = 0
) (
  input  logic       clk,
  input  logic       reset,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);
  localparam logic c_def_grant = (DEFAULT_GRANT != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_aw_done;
  logic   r_w_done;
`ifdef AXI_LITE_ARBITER_RR_EN
  logic   r_ptr;
`endif

  logic        w_req0, w_req1, w_winner, w_win_arvalid;
  logic        w_own_arvalid, w_own_awvalid, w_own_wvalid, w_own_rready, w_own_bready;
  logic [31:0] w_own_araddr, w_own_awaddr, w_own_wdata;
  logic [3:0]  w_own_wmask;
  logic        w_aw_fin, w_w_fin;

  assign w_req0 = m0.arvalid | m0.awvalid;
  assign w_req1 = m1.arvalid | m1.awvalid;

  always_comb begin
    w_winner = w_req1;
    if (w_req0 && w_req1) begin
`ifdef AXI_LITE_ARBITER_RR_EN
      w_winner = r_ptr;
`else
      w_winner = c_def_grant;
`endif
    end
  end

  assign w_win_arvalid = w_winner ? m1.arvalid : m0.arvalid;

  assign w_own_arvalid = r_owner ? m1.arvalid : m0.arvalid;
  assign w_own_araddr  = r_owner ? m1.araddr  : m0.araddr;
  assign w_own_rready  = r_owner ? m1.rready  : m0.rready;
  assign w_own_awvalid = r_owner ? m1.awvalid : m0.awvalid;
  assign w_own_awaddr  = r_owner ? m1.awaddr  : m0.awaddr;
  assign w_own_wvalid  = r_owner ? m1.wvalid  : m0.wvalid;
  assign w_own_wdata   = r_owner ? m1.wdata   : m0.wdata;
  assign w_own_wmask   = r_owner ? m1.wmask   : m0.wmask;
  assign w_own_bready  = r_owner ? m1.bready  : m0.bready;

  // A channel counts as finished once its flag is set or it handshakes this cycle.
  assign w_aw_fin = r_aw_done | (s.awvalid & s.awready);
  assign w_w_fin  = r_w_done  | (s.wvalid  & s.wready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_owner   <= c_def_grant;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef AXI_LITE_ARBITER_RR_EN
      r_ptr     <= c_def_grant;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            r_owner <= w_winner;
            r_state <= w_win_arvalid ? RD_ADDR : WR_ADDR;
`ifdef AXI_LITE_ARBITER_RR_EN
            r_ptr   <= ~w_winner;
`endif
          end
        end
        RD_ADDR: begin
          if (s.arvalid && s.arready) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (s.rvalid && w_own_rready) r_state <= IDLE;
        end
        WR_ADDR: begin
          r_aw_done <= w_aw_fin;
          r_w_done  <= w_w_fin;
          if (w_aw_fin && w_w_fin) r_state <= WR_RESP;
        end
        WR_RESP: begin
          if (s.bvalid && w_own_bready) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s.arvalid  = 1'b0;
    s.araddr   = '0;
    s.rready   = 1'b0;
    s.awvalid  = 1'b0;
    s.awaddr   = '0;
    s.wvalid   = 1'b0;
    s.wdata    = '0;
    s.wmask    = '0;
    s.bready   = 1'b0;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bresp   = '0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bresp   = '0;
    case (r_state)
      RD_ADDR: begin
        s.arvalid = w_own_arvalid;
        s.araddr  = w_own_araddr;
        if (r_owner) m1.arready = s.arready;
        else         m0.arready = s.arready;
      end
      RD_DATA: begin
        s.rready = w_own_rready;
        if (r_owner) begin
          m1.rvalid = s.rvalid;
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
        end
      end
      WR_ADDR: begin
        s.awvalid = w_own_awvalid & ~r_aw_done;
        s.awaddr  = w_own_awaddr;
        s.wvalid  = w_own_wvalid & ~r_w_done;
        s.wdata   = w_own_wdata;
        s.wmask   = w_own_wmask;
        if (r_owner) begin
          m1.awready = s.awready & ~r_aw_done;
          m1.wready  = s.wready & ~r_w_done;
        end else begin
          m0.awready = s.awready & ~r_aw_done;
          m0.wready  = s.wready & ~r_w_done;
        end
      end
      WR_RESP: begin
        s.bready = w_own_bready;
        if (r_owner) begin
          m1.bvalid = s.bvalid;
          m1.bresp  = s.bresp;
        end else begin
          m0.bvalid = s.bvalid;
          m0.bresp  = s.bresp;
        end
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// tb_axi_lite_arbiter: directed, table-driven checks of the 2:1 AXI-Lite arbiter.
module tb_axi_lite_arbiter;
  logic clk;
  logic rst_n;

  axi_lite_if m0_if ();
  axi_lite_if m1_if ();
  axi_lite_if s_if ();

  axi_lite_arbiter #(.DEFAULT_GRANT(0)) dut (
    .clk   (clk),
    .reset (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

`ifdef AXI_LITE_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic [31:0] m_araddr [2];
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wmask  [2];
  logic [1:0]  m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_rresp  [2];
  logic [1:0]  m_bresp  [2];

  assign m0_if.arvalid = m_arvalid[0];
  assign m0_if.araddr  = m_araddr[0];
  assign m0_if.rready  = m_rready[0];
  assign m0_if.awvalid = m_awvalid[0];
  assign m0_if.awaddr  = m_awaddr[0];
  assign m0_if.wvalid  = m_wvalid[0];
  assign m0_if.wdata   = m_wdata[0];
  assign m0_if.wmask   = m_wmask[0];
  assign m0_if.bready  = m_bready[0];
  assign m1_if.arvalid = m_arvalid[1];
  assign m1_if.araddr  = m_araddr[1];
  assign m1_if.rready  = m_rready[1];
  assign m1_if.awvalid = m_awvalid[1];
  assign m1_if.awaddr  = m_awaddr[1];
  assign m1_if.wvalid  = m_wvalid[1];
  assign m1_if.wdata   = m_wdata[1];
  assign m1_if.wmask   = m_wmask[1];
  assign m1_if.bready  = m_bready[1];

  assign m_arready = {m1_if.arready, m0_if.arready};
  assign m_awready = {m1_if.awready, m0_if.awready};
  assign m_wready  = {m1_if.wready,  m0_if.wready};
  assign m_rvalid  = {m1_if.rvalid,  m0_if.rvalid};
  assign m_bvalid  = {m1_if.bvalid,  m0_if.bvalid};
  assign m_rdata[0] = m0_if.rdata;
  assign m_rdata[1] = m1_if.rdata;
  assign m_rresp[0] = m0_if.rresp;
  assign m_rresp[1] = m1_if.rresp;
  assign m_bresp[0] = m0_if.bresp;
  assign m_bresp[1] = m1_if.bresp;

  typedef struct {
    bit          mst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  resp;
    int          d0;
    int          d1;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the arbiter idle.
  task automatic do_read(input vec_t v);
    bit o;
    o = ~v.mst;
    m_arvalid[v.mst] = 1'b1;
    m_araddr[v.mst]  = v.addr;
    m_rready[v.mst]  = 1'b1;
    #1;
    chk("rd_idle_no_arvalid", s_if.arvalid, 1'b0);
    tick();
    #1;
    chk("rd_s_arvalid", s_if.arvalid, 1'b1);
    chkw("rd_s_araddr", s_if.araddr, v.addr);
    s_if.arready = 1'b1;
    #1;
    chk("rd_own_arready", m_arready[v.mst], 1'b1);
    chk("rd_other_arready", m_arready[o], 1'b0);
    tick();
    m_arvalid[v.mst] = 1'b0;
    s_if.arready     = 1'b0;
    for (int i = 0; i < v.d0; i++) begin
      #1;
      chk("rd_wait_rvalid", m_rvalid[v.mst], 1'b0);
      tick();
    end
    s_if.rvalid = 1'b1;
    s_if.rdata  = v.data;
    s_if.rresp  = v.resp;
    #1;
    chk("rd_own_rvalid", m_rvalid[v.mst], 1'b1);
    chkw("rd_own_rdata", m_rdata[v.mst], v.data);
    chkw("rd_own_rresp", 32'(m_rresp[v.mst]), 32'(v.resp));
    chk("rd_other_rvalid", m_rvalid[o], 1'b0);
    chkw("rd_other_rdata", m_rdata[o], 32'h0);
    chk("rd_s_rready", s_if.rready, 1'b1);
    tick();
    s_if.rvalid      = 1'b0;
    s_if.rdata       = 32'h0;
    s_if.rresp       = 2'd0;
    m_rready[v.mst]  = 1'b0;
  endtask

  // Slave holds bvalid high from the start: nothing may reach the owner before both AW and W complete.
  task automatic do_write(input vec_t v);
    bit aw_d, w_d, o;
    int c;
    o = ~v.mst;
    m_awvalid[v.mst] = 1'b1;
    m_awaddr[v.mst]  = v.addr;
    m_wvalid[v.mst]  = 1'b1;
    m_wdata[v.mst]   = v.data;
    m_wmask[v.mst]   = v.mask;
    m_bready[v.mst]  = 1'b1;
    s_if.bvalid      = 1'b1;
    s_if.bresp       = v.resp;
    #1;
    chk("wr_idle_no_awvalid", s_if.awvalid, 1'b0);
    tick();
    aw_d = 1'b0;
    w_d  = 1'b0;
    c    = 0;
    while (!(aw_d && w_d) && c < 12) begin
      s_if.awready = !aw_d && (c == v.d0);
      s_if.wready  = !w_d && (c == v.d1);
      #1;
      chk("wr_no_early_bvalid", m_bvalid[v.mst], 1'b0);
      chk("wr_awvalid_mask", s_if.awvalid, !aw_d);
      chk("wr_wvalid_mask", s_if.wvalid, !w_d);
      chk("wr_other_awready", m_awready[o], 1'b0);
      if (s_if.awvalid && s_if.awready) begin
        chkw("wr_s_awaddr", s_if.awaddr, v.addr);
        chk("wr_own_awready", m_awready[v.mst], 1'b1);
        aw_d = 1'b1;
      end
      if (s_if.wvalid && s_if.wready) begin
        chkw("wr_s_wdata", s_if.wdata, v.data);
        chkw("wr_s_wmask", 32'(s_if.wmask), 32'(v.mask));
        chk("wr_own_wready", m_wready[v.mst], 1'b1);
        w_d = 1'b1;
      end
      tick();
      c++;
    end
    s_if.awready     = 1'b0;
    s_if.wready      = 1'b0;
    m_awvalid[v.mst] = 1'b0;
    m_wvalid[v.mst]  = 1'b0;
    if (!(aw_d && w_d)) fail_timeout("wr_addr_phase");
    #1;
    chk("wr_own_bvalid", m_bvalid[v.mst], 1'b1);
    chkw("wr_own_bresp", 32'(m_bresp[v.mst]), 32'(v.resp));
    chk("wr_other_bvalid", m_bvalid[o], 1'b0);
    chk("wr_s_bready", s_if.bready, 1'b1);
    tick();
    s_if.bvalid     = 1'b0;
    s_if.bresp      = 2'd0;
    m_bready[v.mst] = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t tail;
  int   ng, cyc;
  logic got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h1234_5678, 4'h0, 2'd0, 3, 0};
    vecs[1] = '{1'b1, 1'b1, 32'ha000_03f8, 32'h0000_0041, 4'h1, 2'd0, 0, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h1000_0004, 32'hdead_beef, 4'h0, 2'd2, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h8000_1000, 32'hcafe_f00d, 4'hf, 2'd1, 2, 0};
    vecs[4] = '{1'b0, 1'b1, 32'h2000_0010, 32'h0bad_cafe, 4'h6, 2'd3, 1, 1};
    vecs[5] = '{1'b1, 1'b0, 32'h3000_0020, 32'h55aa_33cc, 4'h0, 2'd0, 1, 0};

    rst_n = 1'b0;
    m_arvalid = 2'b00; m_awvalid = 2'b00; m_wvalid = 2'b00;
    m_rready  = 2'b00; m_bready  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = 32'h0; m_awaddr[i] = 32'h0; m_wdata[i] = 32'h0; m_wmask[i] = 4'h0;
    end
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0; s_if.rresp = 2'd0;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0; s_if.bresp = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    chkw("reset_s_outputs",
         32'({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready}), 32'h0);
    chkw("reset_m_outputs",
         32'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else            do_read(vecs[i]);
    end

    // m0 requests read and write together: read first, write in a later idle cycle.
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h0000_7000; m_rready[0] = 1'b1;
    m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h0000_7004; m_wvalid[0] = 1'b1;
    m_wdata[0] = 32'h1111_2222; m_wmask[0] = 4'hf; m_bready[0] = 1'b1;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; s_if.rdata = 32'h3333_4444;
    s_if.awready = 1'b1; s_if.wready = 1'b1; s_if.bvalid = 1'b1; s_if.bresp = 2'd0;
    #1;
    chk("rw_idle_arvalid", s_if.arvalid, 1'b0);
    chk("rw_idle_awvalid", s_if.awvalid, 1'b0);
    tick(); #1;
    chk("rw_read_first", s_if.arvalid, 1'b1);
    chk("rw_no_aw_yet", s_if.awvalid, 1'b0);
    chk("rw_arready", m_arready[0], 1'b1);
    tick();
    m_arvalid[0] = 1'b0;
    #1;
    chk("rw_rvalid", m_rvalid[0], 1'b1);
    chkw("rw_rdata", m_rdata[0], 32'h3333_4444);
    chk("rw_awready_blocked", m_awready[0], 1'b0);
    tick(); #1;
    chk("rw_idle2_awvalid", s_if.awvalid, 1'b0);
    chk("rw_idle2_rvalid", m_rvalid[0], 1'b0);
    tick(); #1;
    chk("rw_write_granted", s_if.awvalid, 1'b1);
    chkw("rw_awaddr", s_if.awaddr, 32'h0000_7004);
    chkw("rw_wdata", s_if.wdata, 32'h1111_2222);
    tick();
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
    #1;
    chk("rw_bvalid", m_bvalid[0], 1'b1);
    tick();
    m_bready[0] = 1'b0; m_rready[0] = 1'b0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0;
    #1;
    chk("rw_done_idle", s_if.awvalid, 1'b0);
    tick();

    // Owner stalls rready for 5 cycles; m1's request must wait.
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h0000_5000; m_rready[0] = 1'b0;
    tick();
    s_if.arready = 1'b1;
    tick();
    m_arvalid[0] = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'ha5a5_0001;
    m_arvalid[1] = 1'b1; m_araddr[1] = 32'h0000_6000; m_rready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rvalid", m_rvalid[0], 1'b1);
      chkw("stall_rdata", m_rdata[0], 32'ha5a5_0001);
      chk("stall_m1_arready", m_arready[1], 1'b0);
      chk("stall_s_arvalid", s_if.arvalid, 1'b0);
      chk("stall_s_rready", s_if.rready, 1'b0);
      tick();
    end
    m_rready[0] = 1'b1;
    #1;
    chk("stall_release_rready", s_if.rready, 1'b1);
    tick();
    s_if.rvalid = 1'b0; s_if.rdata = 32'h0; m_rready[0] = 1'b0;
    tail = '{1'b1, 1'b0, 32'h0000_6000, 32'h0000_0099, 4'h0, 2'd0, 1, 0};
    do_read(tail);

    // Reset in RD_DATA with rvalid low; m1 pending must be granted after release.
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h0000_3000; m_rready[0] = 1'b1;
    tick();
    s_if.arready = 1'b1;
    tick();
    m_arvalid[0] = 1'b0; s_if.arready = 1'b0;
    m_arvalid[1] = 1'b1; m_araddr[1] = 32'h0000_4000; m_rready[1] = 1'b1;
    #1;
    chk("rst_pre_rready", s_if.rready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_rready", s_if.rready, 1'b0);
    chkw("rst_async_m_outputs",
         32'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 32'h0);
    chk("rst_async_arvalid", s_if.arvalid, 1'b0);
    tick(); #1;
    chk("rst_held_no_grant", s_if.arvalid, 1'b0);
    tick();
    rst_n = 1'b1; m_rready[0] = 1'b0;
    #1;
    chk("rst_release_no_grant", s_if.arvalid, 1'b0);
    tick(); #1;
    chk("rst_regrant_arvalid", s_if.arvalid, 1'b1);
    chkw("rst_regrant_araddr", s_if.araddr, 32'h0000_4000);
    s_if.arready = 1'b1;
    #1;
    chk("rst_regrant_arready", m_arready[1], 1'b1);
    tick();
    m_arvalid[1] = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_0077;
    #1;
    chk("rst_regrant_rvalid", m_rvalid[1], 1'b1);
    chkw("rst_regrant_rdata", m_rdata[1], 32'h0000_0077);
    tick();
    s_if.rvalid = 1'b0; s_if.rdata = 32'h0; m_rready[1] = 1'b0;

    // Both masters read every idle cycle; check the tie-break order from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_arvalid = 2'b11; m_araddr[0] = 32'h0000_0100; m_araddr[1] = 32'h0000_0200;
    m_rready = 2'b11;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_5a5a;
    ng = 0;
    cyc = 0;
    while (ng < 4 && cyc < 40) begin
      #1;
      chk("tie_single_ready", m_arready[0] & m_arready[1], 1'b0);
      if (m_arready[0] || m_arready[1]) begin
        got = m_arready[1];
        chk("tie_grant_order", got, RR ? ng[0] : 1'b0);
        chkw("tie_araddr", s_if.araddr, got ? 32'h0000_0200 : 32'h0000_0100);
        ng++;
      end
      tick();
      cyc++;
    end
    if (ng < 4) fail_timeout("tie_grants");
    m_arvalid = 2'b00;
    tick();
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0; m_rready = 2'b00;
    tick(); #1;
    chk("tie_final_idle", s_if.arvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
